// File: rtl/stump_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// stump_sequencer_pkg
// Shared Stump definitions: processor state encodings seen by the control
// decoder, the opcode field position and the load/store opcode.
// No ports (package).
// ----------------------------------------------------------------------------
package stump_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam int       OPCODE_MSB = 15;
    localparam int       OPCODE_LSB = 13;
    localparam logic [2:0] LDST     = 3'b011;

    // True when the instruction needs a data memory phase after EXECUTE.
    function automatic logic is_ldst(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB] == LDST;
    endfunction

endpackage

// File: rtl/stump_sequencer.sv
// ----------------------------------------------------------------------------
// stump_sequencer
// Sequencing controller for the Stump datapath. Owns the FETCH / EXECUTE /
// MEMORY / HALT state register, handshakes each memory phase on mem_ready,
// provides debug halt / single-step / resume, halts with a sticky bus error
// when memory does not answer in time, and counts retired instructions.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   ir[15:0]     in   current instruction register (valid from EXECUTE)
//   mem_ready    in   memory completes the current transfer this cycle
//   halt_req     in   level: halt at the next instruction boundary
//   step_req     in   pulse: in HALT, run exactly one instruction
//   resume_req   in   pulse: in HALT, run freely and clear bus_error
//   state[1:0]   out  current state to the control decoder
//   mem_req      out  memory transfer in progress
//   ir_en        out  load the instruction register
//   halted       out  high in HALT
//   bus_error    out  sticky memory timeout flag
//   instr_count  out  retired instruction count (wraps)
// ----------------------------------------------------------------------------
module stump_sequencer
    import stump_sequencer_pkg::*;
#(
    parameter int TIMEOUT      = 15,
    parameter int COUNT_W      = 16,
    parameter int START_HALTED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        ir,
    input  logic               mem_ready,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               resume_req,
    output logic [1:0]         state,
    output logic               mem_req,
    output logic               ir_en,
    output logic               halted,
    output logic               bus_error,
    output logic [COUNT_W-1:0] instr_count
);

    localparam state_t     RESET_STATE  = (START_HALTED != 0) ? HALT : FETCH;
    // The counter holds the number of wait cycles already spent; the wait
    // cycle that would bring it to TIMEOUT is the one that errors out.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic        halt_pend;
    logic        step_flag;
    logic        retire;
    logic        timeout;
    logic        enter_halt;
    state_t      boundary;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state_q;
        retire     = 1'b0;
        timeout    = 1'b0;
        // halt_req is folded in directly so a request seen in the retiring
        // cycle itself still stops at this boundary.
        boundary   = (halt_pend || step_flag || halt_req) ? HALT : FETCH;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    next_state = EXECUTE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout    = 1'b1;
                    next_state = HALT;
                end
            end
            EXECUTE: begin
                if (is_ldst(ir)) begin
                    next_state = MEMORY;
                end else begin
                    retire     = 1'b1;
                    next_state = boundary;
                end
            end
            MEMORY: begin
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = boundary;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout    = 1'b1;
                    next_state = HALT;
                end
            end
            HALT: begin
                if (resume_req || step_req) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // Outputs decoded from state (mem_req/ir_en also see mem_ready)
    always_comb begin
        mem_req = 1'b0;
        ir_en   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
            end
            MEMORY:  mem_req = 1'b1;
            HALT:    halted  = 1'b1;
            default: ;
        endcase
    end

    assign enter_halt = (state_q != HALT) && (next_state == HALT);

    // Wait counter, debug flags, bus error and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= 8'd0;
            halt_pend   <= 1'b0;
            step_flag   <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            if (next_state != state_q) begin
                wait_cnt <= 8'd0;
            end else if ((state_q == FETCH || state_q == MEMORY) && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (enter_halt) begin
                halt_pend <= 1'b0;
            end else if (state_q != HALT && halt_req) begin
                halt_pend <= 1'b1;
            end

            // Resume wins over a simultaneous step, so no step flag then.
            if (enter_halt) begin
                step_flag <= 1'b0;
            end else if (state_q == HALT && step_req && !resume_req) begin
                step_flag <= 1'b1;
            end

            if (timeout) begin
                bus_error <= 1'b1;
            end else if (state_q == HALT && resume_req) begin
                bus_error <= 1'b0;
            end

            if (retire) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stump_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stump_sequencer
// Bench for stump_sequencer. Instance dut: TIMEOUT=4, COUNT_W=4, starts in
// FETCH. Instance dut_b: START_HALTED=1, used for the start-halted stepping
// sequence.
// ----------------------------------------------------------------------------
module tb_stump_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [15:0] I_ADD  = 16'h0000;
    localparam logic [15:0] I_SUB  = 16'h4000;
    localparam logic [15:0] I_AND  = 16'h8000;
    localparam logic [15:0] I_LDST = 16'h6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [15:0]   ir;
    logic          mem_ready, halt_req, step_req, resume_req;
    logic [1:0]    state;
    logic          mem_req, ir_en, halted, bus_error;
    logic [CW-1:0] instr_count;

    logic [15:0]   b_ir;
    logic          b_mem_ready, b_halt_req, b_step_req, b_resume_req;
    logic [1:0]    b_state;
    logic          b_mem_req, b_ir_en, b_halted, b_bus_error;
    logic [CW-1:0] b_instr_count;

    stump_sequencer #(.TIMEOUT(TO), .COUNT_W(CW), .START_HALTED(0)) dut (
        .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .state(state), .mem_req(mem_req), .ir_en(ir_en), .halted(halted),
        .bus_error(bus_error), .instr_count(instr_count)
    );

    stump_sequencer #(.TIMEOUT(TO), .COUNT_W(CW), .START_HALTED(1)) dut_b (
        .clk(clk), .rst(rst), .ir(b_ir), .mem_ready(b_mem_ready),
        .halt_req(b_halt_req), .step_req(b_step_req), .resume_req(b_resume_req),
        .state(b_state), .mem_req(b_mem_req), .ir_en(b_ir_en), .halted(b_halted),
        .bus_error(b_bus_error), .instr_count(b_instr_count)
    );

    typedef struct {
        logic [15:0] ir;
        logic        mr, h, s, r;
        logic [1:0]  st;
        logic        mreq, iren, hlt, berr;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       mreq, iren, hlt, berr;
        logic [3:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic mr, input logic h,
                                input logic s, input logic r, input logic [1:0] st,
                                input logic mreq, input logic iren, input logic hlt,
                                input logic berr, input logic [3:0] cnt);
        vec_t v;
        v.ir = i; v.mr = mr; v.h = h; v.s = s; v.r = r;
        v.st = st; v.mreq = mreq; v.iren = iren; v.hlt = hlt; v.berr = berr; v.cnt = cnt;
        return v;
    endfunction

    // Called at a falling edge: drive inputs, record the expectation, sample
    // one time unit before the rising edge, then move to the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        ir         = v.ir;
        mem_ready  = v.mr;
        halt_req   = v.h;
        step_req   = v.s;
        resume_req = v.r;
        exp_q.push_back('{v.st, v.mreq, v.iren, v.hlt, v.berr, v.cnt});
        #4;
        e = exp_q.pop_front();
        check({tag, ".state"},     32'(state),       32'(e.st));
        check({tag, ".mem_req"},   32'(mem_req),     32'(e.mreq));
        check({tag, ".ir_en"},     32'(ir_en),       32'(e.iren));
        check({tag, ".halted"},    32'(halted),      32'(e.hlt));
        check({tag, ".bus_error"}, 32'(bus_error),   32'(e.berr));
        check({tag, ".count"},     32'(instr_count), 32'(e.cnt));
        @(negedge clk);
    endtask

    initial begin
        //            ir      mr h  s  r   st   mreq iren hlt berr cnt
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd0)); // free run
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd1));
        vecs.push_back(mk(I_LDST, 1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd1));
        vecs.push_back(mk(I_LDST, 1, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd2));
        vecs.push_back(mk(I_SUB,  1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd2));
        vecs.push_back(mk(I_ADD,  0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'd3)); // fetch waits
        vecs.push_back(mk(I_ADD,  0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(I_ADD,  0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd3)); // ready at limit
        vecs.push_back(mk(I_AND,  0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd3));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd4));
        vecs.push_back(mk(I_LDST, 1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd4));
        vecs.push_back(mk(I_LDST, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd4)); // memory timeout
        vecs.push_back(mk(I_LDST, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd4));
        vecs.push_back(mk(I_LDST, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd4));
        vecs.push_back(mk(I_LDST, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd4));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd3, 0, 0, 1, 1, 4'd4));
        vecs.push_back(mk(I_ADD,  0, 0, 0, 1, 2'd3, 0, 0, 1, 1, 4'd4)); // resume
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd4));
        vecs.push_back(mk(I_LDST, 1, 1, 0, 0, 2'd1, 0, 0, 0, 0, 4'd4)); // halt in LDST exec
        vecs.push_back(mk(I_LDST, 1, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd4));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd3, 0, 0, 1, 0, 4'd5));
        vecs.push_back(mk(I_ADD,  1, 0, 1, 0, 2'd3, 0, 0, 1, 0, 4'd5)); // step
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd3, 0, 0, 1, 0, 4'd6));
        vecs.push_back(mk(I_ADD,  1, 0, 1, 1, 2'd3, 0, 0, 1, 0, 4'd6)); // step+resume
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd6));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd6));
        vecs.push_back(mk(I_ADD,  1, 1, 0, 0, 2'd0, 1, 1, 0, 0, 4'd7)); // halt in fetch
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd7));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd3, 0, 0, 1, 0, 4'd8));
        vecs.push_back(mk(I_ADD,  1, 1, 0, 1, 2'd3, 0, 0, 1, 0, 4'd8)); // resume, halt held
        vecs.push_back(mk(I_ADD,  1, 1, 0, 0, 2'd0, 1, 1, 0, 0, 4'd8));
        vecs.push_back(mk(I_ADD,  1, 1, 0, 0, 2'd1, 0, 0, 0, 0, 4'd8));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 1, 2'd3, 0, 0, 1, 0, 4'd9));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd9));

        rst = 1'b0;
        ir = I_ADD; mem_ready = 1'b0; halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0;
        b_ir = I_ADD; b_mem_ready = 1'b1; b_halt_req = 1'b0; b_step_req = 1'b0; b_resume_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values of both instances
        check("rst.state",     32'(state),         32'd0);
        check("rst.mem_req",   32'(mem_req),       32'd1);
        check("rst.halted",    32'(halted),        32'd0);
        check("rst.bus_error", 32'(bus_error),     32'd0);
        check("rst.count",     32'(instr_count),   32'd0);
        check("rst_b.state",   32'(b_state),       32'd3);
        check("rst_b.halted",  32'(b_halted),      32'd1);
        check("rst_b.mem_req", 32'(b_mem_req),     32'd0);
        check("rst_b.count",   32'(b_instr_count), 32'd0);

        rst = 1'b1;
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Start-halted instance: two single steps, then step+resume runs freely
        @(negedge clk);
        check("b.idle_state", 32'(b_state), 32'd3);
        for (int k = 1; k <= 2; k++) begin
            b_step_req = 1'b1;
            @(negedge clk);
            b_step_req = 1'b0;
            check($sformatf("b.step%0d_fetch", k), 32'(b_state), 32'd0);
            @(negedge clk);
            check($sformatf("b.step%0d_exec", k), 32'(b_state), 32'd1);
            @(negedge clk);
            check($sformatf("b.step%0d_halted", k), 32'(b_halted), 32'd1);
            check($sformatf("b.step%0d_count", k), 32'(b_instr_count), 32'(k));
            @(negedge clk);
            @(negedge clk);
            check($sformatf("b.step%0d_stays", k), 32'(b_state), 32'd3);
        end
        b_step_req = 1'b1;
        b_resume_req = 1'b1;
        @(negedge clk);
        b_step_req = 1'b0;
        b_resume_req = 1'b0;
        repeat (4) @(negedge clk);
        check("b.freerun_state",  32'(b_state),       32'd0);
        check("b.freerun_halted", 32'(b_halted),      32'd0);
        check("b.freerun_count",  32'(b_instr_count), 32'd4);

        // Counter wrap: 17 instructions on a 4-bit counter
        rst = 1'b0;
        #1;
        check("rst2.state", 32'(state),       32'd0);
        check("rst2.count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            apply(mk(I_ADD, 1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'(i)), $sformatf("wrap%0d.f", i));
            apply(mk(I_SUB, 1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'(i)), $sformatf("wrap%0d.e", i));
        end
        apply(mk(I_ADD,  1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 4'd1), "wrap.done");
        apply(mk(I_LDST, 1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 4'd1), "mid.exec");
        apply(mk(I_LDST, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'd1), "mid.mem");

        // Asynchronous reset in the middle of a memory phase, between edges
        #2;
        rst = 1'b0;
        #1;
        check("async.state",     32'(state),       32'd0);
        check("async.count",     32'(instr_count), 32'd0);
        check("async.bus_error", 32'(bus_error),   32'd0);
        check("async.halted",    32'(halted),      32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
